serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial sequencer placed directly upstream and downstream of the 1-bit full-adder cell.
- Upstream: latches two WIDTH-bit operands and a carry-in, then drives the cell one bit per clock, LSB first.
- Downstream: captures the cell's sum bit and carry-out on each clock and assembles the WIDTH-bit result.
- Closes the carry loop through a register, so one full-adder cell implements a WIDTH-bit adder in WIDTH cycles.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- op_a  input  WIDTH  operand A; sampled on the accepting edge.
- op_b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  initial carry-in; sampled on the accepting edge.
- fa_a  output  1  bit of A presented to the full-adder cell.
- fa_b  output  1  bit of B presented to the full-adder cell.
- fa_ci  output  1  registered carry presented to the full-adder cell.
- fa_s  input  1  sum bit returned by the cell (combinational, same cycle).
- fa_co  input  1  carry-out returned by the cell (combinational, same cycle).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result of the last completed addition.
- cout  output  1  final carry of the last completed addition.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; a_sh, b_sh, sum_sh, carry_r, cnt, sum, cout all 0; busy=0; done=0.
- FSM states: IDLE, RUN, DONE. Encoding is one-hot, taken from the package.
- IDLE:
  - fa_a, fa_b, fa_ci driven 0.
  - On an edge with start=1: a_sh<=op_a, b_sh<=op_b, carry_r<=cin, cnt<=0, go to RUN.
- RUN:
  - Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_ci=carry_r.
  - Each edge: a_sh and b_sh shift right with 0 fill; sum_sh<={fa_s, sum_sh[WIDTH-1:1]}; carry_r<=fa_co; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={fa_s, sum_sh[WIDTH-1:1]}, cout<=fa_co, go to DONE.
- DONE: done=1 for exactly one cycle; fa_* driven 0; next edge goes to IDLE unconditionally.
- busy and done are decoded from registered state, so they are glitch-free.
- Latency: start accepted at edge E0; RUN spans E1..EW; done high during the cycle after EW. That is WIDTH+1 cycles from the accepting edge to done. busy is high for WIDTH cycles.
- Throughput: a new start is accepted in IDLE, so the earliest next accepting edge is the one after done. Period is WIDTH+2 cycles.
- start during RUN or DONE is ignored. Operands are not re-sampled.
- op_a, op_b and cin may change freely after the accepting edge.
- sum and cout hold their value until the next completion. They are never partially updated during RUN.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1). Overflow wraps; there is no saturation.
- cnt width is clog2(WIDTH). cnt never exceeds WIDTH-1.
- Reset mid-RUN aborts the operation. sum and cout clear to 0, and no done pulse is produced.

Decomposition:
- Shared package serial_add_pkg holds:
  - state typedef (IDLE/RUN/DONE, one-hot),
  - DEFAULT_WIDTH=4,
  - CNT_W function (clog2).
- Sub-module serial_shreg: parameterised WIDTH right-shift register with parallel load, shift-enable and serial-in.
  - Instantiated three times: a_sh, b_sh, sum_sh.
- The full-adder cell stays outside this block. The bench and the top level connect fa_* to it.

Test Plan:
- WIDTH=4, op_a=5, op_b=3, cin=0, start pulse -> fa_a sequence 1,0,1,0; fa_b sequence 1,1,0,0; sum=8, cout=0; done 5 cycles after the accepting edge; busy high 4 cycles.
- op_a=15, op_b=1, cin=0 -> sum=0, cout=1; fa_ci sequence 0,1,1,1.
- op_a=15, op_b=15, cin=1 -> sum=15, cout=1.
- Start 6+2; hold start=1 with op_a=9 throughout RUN -> result sum=8 only; second operation begins only after DONE→IDLE; sum=8 holds until that operation completes.
- Start 7+7; assert rst after 2 RUN cycles -> immediately state=IDLE, busy=0, sum=0, cout=0; no done pulse; a following 1+1 returns sum=2.
- Back-to-back: start held high continuously with operands 3+4 then 10+10 -> done pulses 6 cycles apart; sum=7,cout=0 then sum=4,cout=1.

Source files
------------

// File: rtl/serial_add_seq_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // One-hot sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  // Bit-counter width: enough to hold 0..w-1.
  function automatic int CNT_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Request/result bus of the serial adder: operands in, status and result out.
interface serial_add_if import serial_add_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_seq_shreg.sv
// Right-shift register with parallel load (priority), shift-enable and serial-in at the MSB.
module serial_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift; shifting moves toward the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           q <= '0;
    else if (load)     q <= d;
    else if (shift_en) q <= {ser_in, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: feeds an external 1-bit full-adder cell LSB first,
// closes its carry through a register and assembles the WIDTH-bit result.
module serial_add_seq import serial_add_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_ci,
  input  logic         fa_s,
  input  logic         fa_co
);

  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [WIDTH-1:0] a_q, b_q, s_q, s_nxt;
  logic             accept, run;
  logic             unused_bits;

  assign accept = (state == IDLE) && bus.start;
  assign run    = (state == RUN);

  // Result as it will look after this edge's shift; committed whole on the last bit.
  assign s_nxt  = {fa_s, s_q[WIDTH-1:1]};

  // Only the LSBs of the operand shifters and the upper sum bits are consumed here.
  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], s_q[0]};

  serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .rst(rst), .load(accept), .d(bus.op_a),
    .shift_en(run), .ser_in(1'b0), .q(a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .rst(rst), .load(accept), .d(bus.op_b),
    .shift_en(run), .ser_in(1'b0), .q(b_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_sum_sh (
    .clk(clk), .rst(rst), .load(1'b0), .d('0),
    .shift_en(run), .ser_in(fa_s), .q(s_q)
  );

  // Cell inputs are quiet outside RUN.
  assign fa_a  = run ? a_q[0] : 1'b0;
  assign fa_b  = run ? b_q[0] : 1'b0;
  assign fa_ci = run ? carry_r : 1'b0;

  // Status decoded straight from the state register, so glitch-free.
  assign bus.busy = run;
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

  // Sequencer: accept in IDLE, one bit per edge in RUN, single DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      carry_r <= 1'b0;
      cnt     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            carry_r <= bus.cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          carry_r <= fa_co;
          if (cnt == LAST) begin
            cnt    <= '0;
            sum_r  <= s_nxt;
            cout_r <= fa_co;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: models the full-adder cell, checks results against
// plain integer addition and checks timing, bit ordering and reset behaviour.
module tb_serial_add_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  int vecs = 0;
  int errs = 0;

  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co)
  );

  // The 1-bit full-adder cell that sits outside the sequencer.
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Carry into each bit position, from integer arithmetic on the low bits.
  function automatic logic [W-1:0] carries(input int a, input int b, input int ci);
    logic [W-1:0] c;
    for (int k = 0; k < W; k++) begin
      int m;
      m = (1 << k) - 1;
      c[k] = (((a & m) + (b & m) + ci) >> k) & 1;
    end
    return c;
  endfunction

  // Launch one addition from IDLE and observe it until done (bounded).
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int done_cyc, output int busy_cyc,
                        output logic [W-1:0] sa, output logic [W-1:0] sb,
                        output logic [W-1:0] sci, output logic [W-1:0] rs,
                        output logic rc, output bit held, output logic done_after);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.cin = ci;
    tick();
    bus.start = 1'b0;
    bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.cin = 1'($urandom);
    done_cyc = -1; busy_cyc = 0; held = 1'b1;
    sa = '0; sb = '0; sci = '0; rs = 'x; rc = 1'bx; done_after = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (bus.done === 1'b1) begin
        done_cyc = t + 1;
        rs = bus.sum;
        rc = bus.cout;
        break;
      end
      if (bus.busy === 1'b1) begin
        if (busy_cyc < W) begin
          sa[busy_cyc]  = fa_a;
          sb[busy_cyc]  = fa_b;
          sci[busy_cyc] = fa_ci;
        end
        busy_cyc++;
        if (bus.sum !== last_sum || bus.cout !== last_cout) held = 1'b0;
      end
      tick();
    end
    if (done_cyc > 0) begin
      tick();
      done_after = bus.done;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      errs++;
      $display("FAIL reset_status: busy=%b done=%b cout=%b sum=%0d expected all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    vecs++;
    if ({fa_a, fa_b, fa_ci} !== 3'b000) begin
      errs++;
      $display("FAIL reset_fa: fa_a/b/ci=%b%b%b expected 000", fa_a, fa_b, fa_ci);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vecs++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3] = '{4'd5, 4'd15, 4'd15};
    logic [W-1:0] tb [3] = '{4'd3, 4'd1,  4'd15};
    logic         tc [3] = '{1'b0, 1'b0,  1'b1};
    logic [W-1:0] es [3] = '{4'd8, 4'd0,  4'd15};
    logic         ec [3] = '{1'b0, 1'b1,  1'b1};
    int dc, bc; logic [W-1:0] sa, sb, sci, rs; logic rc, da; bit held;
    for (int i = 0; i < 3; i++) begin
      do_add(ta[i], tb[i], tc[i], dc, bc, sa, sb, sci, rs, rc, held, da);
      vecs++;
      if (rs !== es[i] || rc !== ec[i]) begin
        errs++;
        $display("FAIL dir%0d_result: got cout=%b sum=%0d expected cout=%b sum=%0d",
                 i, rc, rs, ec[i], es[i]);
      end
      vecs++;
      if (dc !== W + 1 || bc !== W) begin
        errs++;
        $display("FAIL dir%0d_timing: done cycle %0d busy %0d expected %0d and %0d",
                 i, dc, bc, W + 1, W);
      end
      vecs++;
      if (sa !== ta[i] || sb !== tb[i]) begin
        errs++;
        $display("FAIL dir%0d_fa_ab: fa_a seq %b fa_b seq %b expected %b %b",
                 i, sa, sb, ta[i], tb[i]);
      end
      vecs++;
      if (held !== 1'b1 || da !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d_hold_pulse: held=%b done_next=%b expected 1 0", i, held, da);
      end
      last_sum = es[i]; last_cout = ec[i];
      if (i == 1) begin
        vecs++;
        if (sci !== 4'b1110) begin
          errs++;
          $display("FAIL dir1_fa_ci: fa_ci seq (lsb first) %b expected 1110", sci);
        end
      end
    end
  endtask

  // start held high through RUN with a new operand: must not disturb the running add.
  task automatic test_start_ignored();
    int dc; bit held;
    bus.start = 1'b1; bus.op_a = 4'd6; bus.op_b = 4'd2; bus.cin = 1'b0;
    tick();
    bus.op_a = 4'd9;
    dc = -1; held = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (bus.done === 1'b1) begin dc = t + 1; break; end
      if (bus.sum !== last_sum) held = 1'b0;
      tick();
    end
    vecs++;
    if (dc !== W + 1 || bus.sum !== 4'd8 || bus.cout !== 1'b0 || held !== 1'b1) begin
      errs++;
      $display("FAIL ign_first: done cycle %0d sum=%0d cout=%b held=%b expected %0d 8 0 1",
               dc, bus.sum, bus.cout, held, W + 1);
    end
    last_sum = 4'd8; last_cout = 1'b0;
    tick();
    vecs++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL ign_idle_gap: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    tick();
    bus.start = 1'b0;
    dc = -1; held = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (bus.done === 1'b1) begin dc = t + 1; break; end
      if (bus.sum !== last_sum) held = 1'b0;
      tick();
    end
    vecs++;
    if (dc !== W + 1 || bus.sum !== 4'd11 || held !== 1'b1) begin
      errs++;
      $display("FAIL ign_second: done cycle %0d sum=%0d held=%b expected %0d 11 1",
               dc, bus.sum, held, W + 1);
    end
    last_sum = 4'd11; last_cout = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int dones; int dc, bc; logic [W-1:0] sa, sb, sci, rs; logic rc, da; bit held;
    bus.start = 1'b1; bus.op_a = 4'd7; bus.op_b = 4'd7; bus.cin = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (bus.busy !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || fa_a !== 1'b0) begin
      errs++;
      $display("FAIL abort_clear: busy=%b sum=%0d cout=%b fa_a=%b expected 0 0 0 0",
               bus.busy, bus.sum, bus.cout, fa_a);
    end
    #1 rst = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    dones = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    vecs++;
    if (dones !== 0) begin
      errs++;
      $display("FAIL abort_no_done: %0d done pulses expected 0", dones);
    end
    do_add(4'd1, 4'd1, 1'b0, dc, bc, sa, sb, sci, rs, rc, held, da);
    vecs++;
    if (rs !== 4'd2 || rc !== 1'b0 || dc !== W + 1) begin
      errs++;
      $display("FAIL abort_recover: sum=%0d cout=%b done cycle %0d expected 2 0 %0d",
               rs, rc, dc, W + 1);
    end
    last_sum = 4'd2; last_cout = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [W-1:0] s1, s2; logic c1, c2;
    d1 = -1; d2 = -1; s1 = 'x; s2 = 'x; c1 = 1'bx; c2 = 1'bx;
    bus.start = 1'b1; bus.op_a = 4'd3; bus.op_b = 4'd4; bus.cin = 1'b0;
    tick();
    bus.op_a = 4'd10; bus.op_b = 4'd10;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin d1 = t; s1 = bus.sum; c1 = bus.cout; end
        else begin d2 = t; s2 = bus.sum; c2 = bus.cout; break; end
      end
    end
    bus.start = 1'b0;
    vecs++;
    if (d1 < 0 || d2 < 0 || d2 - d1 !== W + 2) begin
      errs++;
      $display("FAIL b2b_period: done at %0d and %0d expected %0d apart", d1, d2, W + 2);
    end
    vecs++;
    if (s1 !== 4'd7 || c1 !== 1'b0) begin
      errs++;
      $display("FAIL b2b_first: sum=%0d cout=%b expected 7 0", s1, c1);
    end
    vecs++;
    if (s2 !== 4'd4 || c2 !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second: sum=%0d cout=%b expected 4 1", s2, c2);
    end
    last_sum = 4'd4; last_cout = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int dc, bc, a, b, ci, tot; logic [W-1:0] sa, sb, sci, rs; logic rc, da; bit held;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, (1 << W) - 1);
      b = $urandom_range(0, (1 << W) - 1);
      ci = $urandom_range(0, 1);
      tot = a + b + ci;
      do_add(W'(a), W'(b), 1'(ci), dc, bc, sa, sb, sci, rs, rc, held, da);
      vecs++;
      if ({rc, rs} !== (W+1)'(tot)) begin
        errs++;
        $display("FAIL rnd%0d_result: %0d+%0d+%0d gave %0d expected %0d",
                 n, a, b, ci, {rc, rs}, tot);
      end
      vecs++;
      if (sa !== W'(a) || sb !== W'(b) || sci !== carries(a, b, ci)) begin
        errs++;
        $display("FAIL rnd%0d_fa_seq: a=%b b=%b ci=%b expected %b %b %b",
                 n, sa, sb, sci, W'(a), W'(b), carries(a, b, ci));
      end
      vecs++;
      if (dc !== W + 1 || bc !== W || held !== 1'b1 || da !== 1'b0) begin
        errs++;
        $display("FAIL rnd%0d_timing: done cycle %0d busy %0d held %b done_next %b",
                 n, dc, bc, held, da);
      end
      last_sum = W'(tot); last_cout = 1'((tot >> W) & 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
